// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus for the sequential
// binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    logic [DIGITS-1:0]     nz_mask;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ovf,
        input  nz_mask
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ovf,
        output nz_mask
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per
// clock, with overflow flag and leading-zero mask for display blanking.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    bin2bcd_seq_if.slave io
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FIN
    } state_t;

    state_t state;
    state_t state_n;

    logic [SW-1:0]     scr;
    logic [SW-1:0]     scr_n;
    logic [SW-1:0]     adj;
    logic [BIN_W-1:0]  sr;
    logic [BIN_W-1:0]  sr_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic              ovf_int;
    logic              ovf_int_n;

    logic              busy_q;
    logic              busy_n;
    logic              done_q;
    logic              done_n;
    logic [SW-1:0]     bcd_q;
    logic [SW-1:0]     bcd_n;
    logic              ovf_q;
    logic              ovf_n;
    logic [DIGITS-1:0] mask_q;
    logic [DIGITS-1:0] mask_n;
    logic [DIGITS-1:0] mask_fin;

    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.bcd     = bcd_q;
    assign io.ovf     = ovf_q;
    assign io.nz_mask = mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scr     <= '0;
            sr      <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            mask_q  <= DIGITS'(1);
        end else begin
            scr     <= scr_n;
            sr      <= sr_n;
            cnt     <= cnt_n;
            ovf_int <= ovf_int_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            bcd_q   <= bcd_n;
            ovf_q   <= ovf_n;
            mask_q  <= mask_n;
        end
    end

    // Add-3 per digit; digits are independent, no carry between them.
    always_comb begin
        adj = scr;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
            end
        end
    end

    // Mask bit k set when digit k or any higher digit is nonzero.
    always_comb begin
        mask_fin = '0;
        mask_fin[DIGITS-1] = |scr[SW-1 -: 4];
        for (int k = DIGITS - 2; k >= 0; k--) begin
            mask_fin[k] = mask_fin[k+1] | (|scr[4*k +: 4]);
        end
        mask_fin[0] = 1'b1;
    end

    always_comb begin
        state_n   = state;
        scr_n     = scr;
        sr_n      = sr;
        cnt_n     = cnt;
        ovf_int_n = ovf_int;
        busy_n    = busy_q;
        done_n    = 1'b0;
        bcd_n     = bcd_q;
        ovf_n     = ovf_q;
        mask_n    = mask_q;
        unique case (state)
            IDLE: begin
                if (io.start) begin
                    state_n   = CONV;
                    sr_n      = io.bin;
                    scr_n     = '0;
                    cnt_n     = CW'(BIN_W);
                    ovf_int_n = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            CONV: begin
                // Bit leaving the top digit means value >= 10^DIGITS.
                ovf_int_n = ovf_int | adj[SW-1];
                scr_n     = {adj[SW-2:0], sr[BIN_W-1]};
                sr_n      = sr << 1;
                cnt_n     = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                bcd_n   = scr;
                ovf_n   = ovf_int;
                mask_n  = mask_fin;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
